fft_out_packer: RTL and testbench
=================================

# fft_out_packer

Output stage of the FFT accelerator. Accepts the 1024 complex results streamed out of the accelerator RAM, one 64-bit sample per cycle while `loadOutBuffer` is high, and packs them eight per line into 128 lines of 512 bits. Once all 128 lines are buffered it raises `outFifoReady` and presents the lines to the memory controller, one line per `accelWrBlkDone` handshake.

## Interface
Parameters:
- `SAMPLE_W`, 64: one complex sample; real part in `[63:32]`, imaginary part in `[31:0]`.
- `LINE_W`, 512: width of one memory-controller line.
- `NUM_SAMPLES`, 1024: number of samples per transform.
- Derived, not overridable: `SPL` = `LINE_W`/`SAMPLE_W` = 8; `NUM_LINES` = `NUM_SAMPLES`/`SPL` = 128.

Ports:
- `clk`  in  1  the single clock. Reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous restart, driven by `startF | startI`.
- `loadOutBuffer`  in  1  `sampleIn` is valid this cycle.
- `sampleIn`  in  `SAMPLE_W`  result sample from the accelerator RAM.
- `accelWrBlkDone`  in  1  the memory controller consumed the current line.
- `outFifoReady`  out  1  the buffer is full and the drain is in progress.
- `mcDataOutValid`  out  1  `mcDataOut` holds a valid line.
- `mcDataOut`  out  `LINE_W`  the current line.
- `outFifoEmpty`  out  1  no undelivered lines remain.
- `overflow`  out  1  sticky error flag; set when a sample is dropped.

## Operation
States are `FILL` and `DRAIN`. Reset enters `FILL`.

FILL:
- Each accepted sample goes to lane `k` = `wrCnt[2:0]`, at bits `[64k+63:64k]`. Sample 0 lands in the LSBs.
- Lanes 0–6 are held in a staging register.
- On lane 7, the staging register plus the incoming sample are written as `mem[wrCnt[9:3]]` in the same edge.
- `wrCnt` is 10 bits.
- On acceptance of sample 1023, go to `DRAIN` and set `rdPtr` to 0.

DRAIN:
- `mcDataOut` = `mem[rdPtr]`.
- `accelWrBlkDone` increments `rdPtr`.
- On the handshake with `rdPtr` = 127, go to `FILL` and clear `wrCnt` to 0.

Outputs:
- `outFifoReady` = `mcDataOutValid` = (state == `DRAIN`).
- `mcDataOut` = 0 whenever `mcDataOutValid` is 0.
- `outFifoEmpty` = (state == `FILL`).

Boundary conditions:
- `loadOutBuffer` in `DRAIN`: the sample is dropped and `overflow` is set. `overflow` clears only on `clr` or reset.
- `accelWrBlkDone` in `FILL`: ignored.
- `clr` in any state: go to `FILL`, zero `wrCnt`, `rdPtr` and `overflow`. Memory contents are not cleared.
- `clr` in the same cycle as `loadOutBuffer` or `accelWrBlkDone`: `clr` wins and the other event has no effect.
- `rst_n` low mid-fill or mid-drain: identical to `clr`, but asynchronous.
- `wrCnt` and `rdPtr` never wrap silently. They reset only through the state transitions above.

## Timing
- Reset values: `outFifoReady` 0, `mcDataOutValid` 0, `mcDataOut` 0, `outFifoEmpty` 1, `overflow` 0.
- A sample is accepted on the rising edge where `loadOutBuffer` = 1.
- After 1024 consecutive accepted samples, `outFifoReady` is 1 in the cycle immediately following the 1024th accepting edge (latency 1).
- Line 0 is visible on `mcDataOut` in that same cycle.
- A handshake on edge N makes the next line visible after edge N, so one line per cycle is sustainable.
- After the 128th handshake edge, `outFifoReady` = 0 and `outFifoEmpty` = 1 in the next cycle.
- Gaps in `loadOutBuffer` or `accelWrBlkDone` are allowed. There is no timeout.

## Structure
- Shared package `fft_pkg`: `SAMPLE_W`, `LINE_W`, `NUM_SAMPLES`, the derived `SPL` and `NUM_LINES`, and the state enum `out_state_t {FILL, DRAIN}`.
- Sub-module `fft_line_mem`: a flop array of `NUM_LINES` x `LINE_W`, with one synchronous write port and one combinational read port. It has no reset.
- The top level holds the FSM, `wrCnt`, `rdPtr`, the staging register and `overflow`.

## Test plan
- Reset, then 1024 samples back-to-back with `sampleIn` = `{i, ~i}` for i = 0..1023 → `outFifoReady` = 1 one cycle after the last sample. Line 0 lanes 0..7 = samples 0..7, sample 0 in bits `[63:0]`.
- Drain with `accelWrBlkDone` held high for 128 cycles → line j lane k = `{8j+k, ~(8j+k)}` for every j. Then `outFifoEmpty` = 1, `outFifoReady` = 0, `mcDataOut` = 0.
- Fill with `loadOutBuffer` at 50% duty, and drain with `accelWrBlkDone` at random spacing → identical line contents, and no line skipped or repeated.
- 10 extra samples during `DRAIN` → `overflow` = 1 and line data unchanged. `clr` → `overflow` = 0, state `FILL`.
- `rst_n` low after 500 samples, then a fresh 1024-sample fill → output equals the fresh data only. Same check with `clr` asserted in the same cycle as `loadOutBuffer`: that sample is dropped.
- `accelWrBlkDone` pulsed during `FILL` → no state change, and `outFifoEmpty` remains 1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT accelerator output path.
package fft_pkg;

  localparam int unsigned SAMPLE_W    = 64;
  localparam int unsigned LINE_W      = 512;
  localparam int unsigned NUM_SAMPLES = 1024;

  localparam int unsigned SPL       = LINE_W / SAMPLE_W;
  localparam int unsigned NUM_LINES = NUM_SAMPLES / SPL;

  localparam int unsigned WR_CNT_W = $clog2(NUM_SAMPLES);
  localparam int unsigned LANE_W   = $clog2(SPL);
  localparam int unsigned LINE_AW  = $clog2(NUM_LINES);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } out_state_t;

endpackage

// File: rtl/fft_out_packer_if.sv
// Sample-in / line-out bus between the accelerator RAM, the packer and the memory controller.
interface fft_out_packer_if;
  import fft_pkg::*;

  logic                loadOutBuffer;
  logic [SAMPLE_W-1:0] sampleIn;
  logic                accelWrBlkDone;
  logic                outFifoReady;
  logic                mcDataOutValid;
  logic [LINE_W-1:0]   mcDataOut;
  logic                outFifoEmpty;
  logic                overflow;

  modport master (
    output loadOutBuffer, sampleIn, accelWrBlkDone,
    input  outFifoReady, mcDataOutValid, mcDataOut, outFifoEmpty, overflow
  );

  modport slave (
    input  loadOutBuffer, sampleIn, accelWrBlkDone,
    output outFifoReady, mcDataOutValid, mcDataOut, outFifoEmpty, overflow
  );

endinterface

// File: rtl/fft_line_mem.sv
// Line buffer: NUM_LINES x LINE_W flops, one synchronous write port, one combinational read port.
module fft_line_mem
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [LINE_AW-1:0] wrAddr,
  input  logic [LINE_W-1:0]  wrData,
  input  logic [LINE_AW-1:0] rdAddr,
  output logic [LINE_W-1:0]  rdData
);

  logic [LINE_W-1:0] mem [NUM_LINES];

  // Contents survive restarts; only written lines are ever read back.
  always_ff @(posedge clk) begin
    if (we) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/fft_out_packer.sv
// Packs 1024 streamed samples into 128 lines, then drains them one per memory-controller handshake.
module fft_out_packer
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  fft_out_packer_if.slave  bus
);

  out_state_t                     state, nextState;
  logic [WR_CNT_W-1:0]            wrCnt, wrCntNext;
  logic [LINE_AW-1:0]             rdPtr, rdPtrNext;
  logic                           overflowQ, overflowNext;
  logic [SPL-2:0][SAMPLE_W-1:0]   stage;
  logic                           stageWe, memWe;
  logic [LANE_W-1:0]              lane;
  logic [LINE_W-1:0]              memWrData, memRdData;

  assign lane      = wrCnt[LANE_W-1:0];
  assign memWrData = {bus.sampleIn, stage};

  fft_line_mem u_mem (
    .clk    (clk),
    .we     (memWe),
    .wrAddr (wrCnt[WR_CNT_W-1:LANE_W]),
    .wrData (memWrData),
    .rdAddr (rdPtrNext),
    .rdData (memRdData)
  );

  // Next-state, pointer and strobe logic; clr overrides every other event.
  always_comb begin
    nextState    = state;
    wrCntNext    = wrCnt;
    rdPtrNext    = rdPtr;
    overflowNext = overflowQ;
    stageWe      = 1'b0;
    memWe        = 1'b0;
    if (clr) begin
      nextState    = FILL;
      wrCntNext    = '0;
      rdPtrNext    = '0;
      overflowNext = 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (bus.loadOutBuffer) begin
            if (lane == LANE_W'(SPL - 1)) memWe = 1'b1;
            else                          stageWe = 1'b1;
            if (wrCnt == WR_CNT_W'(NUM_SAMPLES - 1)) begin
              nextState = DRAIN;
              rdPtrNext = '0;
            end else begin
              wrCntNext = WR_CNT_W'(wrCnt + WR_CNT_W'(1));
            end
          end
        end
        DRAIN: begin
          if (bus.loadOutBuffer) overflowNext = 1'b1;
          if (bus.accelWrBlkDone) begin
            if (rdPtr == LINE_AW'(NUM_LINES - 1)) begin
              nextState = FILL;
              wrCntNext = '0;
            end else begin
              rdPtrNext = LINE_AW'(rdPtr + LINE_AW'(1));
            end
          end
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= FILL;
      wrCnt              <= '0;
      rdPtr              <= '0;
      overflowQ          <= 1'b0;
      bus.outFifoReady   <= 1'b0;
      bus.mcDataOutValid <= 1'b0;
      bus.outFifoEmpty   <= 1'b1;
      bus.mcDataOut      <= '0;
    end else begin
      state              <= nextState;
      wrCnt              <= wrCntNext;
      rdPtr              <= rdPtrNext;
      overflowQ          <= overflowNext;
      bus.outFifoReady   <= (nextState == DRAIN);
      bus.mcDataOutValid <= (nextState == DRAIN);
      bus.outFifoEmpty   <= (nextState == FILL);
      bus.mcDataOut      <= (nextState == DRAIN) ? memRdData : '0;
    end
  end

  // Staging register for lanes 0..SPL-2 of the line being assembled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage <= '0;
    else if (stageWe) stage[lane] <= bus.sampleIn;
  end

  assign bus.overflow = overflowQ;

endmodule

// File: tb/tb_fft_out_packer.sv
// Scoreboard bench for fft_out_packer: stimulus pushes expected lines, monitor checks each handshake.
module tb_fft_out_packer;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  always #5 clk = ~clk;

  fft_out_packer_if bus ();

  fft_out_packer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [LINE_W-1:0] expQ [$];
  logic [LINE_W-1:0] modelLine;
  int modelLane = 0;

  function automatic logic [SAMPLE_W-1:0] sampleOf(int i, logic [31:0] salt);
    logic [31:0] v;
    v = 32'(i) + salt;
    return {v, ~v};
  endfunction

  task automatic check(string name, logic [LINE_W-1:0] act, logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic modelReset();
    expQ.delete();
    modelLane = 0;
    modelLine = '0;
  endtask

  // Drive one sample for one cycle; accepted samples feed the line model.
  task automatic sendSample(logic [SAMPLE_W-1:0] s, bit accept);
    bus.loadOutBuffer = 1'b1;
    bus.sampleIn      = s;
    @(posedge clk);
    #1;
    bus.loadOutBuffer = 1'b0;
    if (accept) begin
      modelLine[modelLane*SAMPLE_W +: SAMPLE_W] = s;
      modelLane++;
      if (modelLane == SPL) begin
        expQ.push_back(modelLine);
        modelLane = 0;
      end
    end
  endtask

  task automatic fill(int count, logic [31:0] salt, bit gaps);
    for (int i = 0; i < count; i++) begin
      sendSample(sampleOf(i, salt), 1'b1);
      if (gaps && i < count - 1) begin
        bus.accelWrBlkDone = (i % 64 == 3);
        idle(1);
        bus.accelWrBlkDone = 1'b0;
        if (i == 515) begin
          check("fill_done_empty", LINE_W'(bus.outFifoEmpty), LINE_W'(1));
          check("fill_done_ready", LINE_W'(bus.outFifoReady), LINE_W'(0));
        end
      end
    end
  endtask

  task automatic drain(bit randomGap);
    for (int j = 0; j < NUM_LINES; j++) begin
      if (randomGap) idle(int'($urandom_range(0, 3)));
      bus.accelWrBlkDone = 1'b1;
      @(posedge clk);
      #1;
      bus.accelWrBlkDone = 1'b0;
    end
    check("drain_queue_left", LINE_W'(expQ.size()), LINE_W'(0));
    check("drain_ready",      LINE_W'(bus.outFifoReady), LINE_W'(0));
    check("drain_empty",      LINE_W'(bus.outFifoEmpty), LINE_W'(1));
    check("drain_data_zero",  bus.mcDataOut, '0);
  endtask

  task automatic checkFull(string tag);
    check({tag, "_ready"}, LINE_W'(bus.outFifoReady), LINE_W'(1));
    check({tag, "_valid"}, LINE_W'(bus.mcDataOutValid), LINE_W'(1));
    check({tag, "_empty"}, LINE_W'(bus.outFifoEmpty), LINE_W'(0));
  endtask

  // Monitor: every handshake while a line is presented consumes one expected line.
  always @(negedge clk) begin
    if (rst_n && !clr && bus.mcDataOutValid && bus.accelWrBlkDone) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL line_unexpected: got %0h expected no line", bus.mcDataOut);
      end else begin
        check("line", bus.mcDataOut, expQ.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    bus.loadOutBuffer  = 1'b0;
    bus.sampleIn       = '0;
    bus.accelWrBlkDone = 1'b0;
    modelReset();
    #12;
    check("rst_ready",    LINE_W'(bus.outFifoReady),   LINE_W'(0));
    check("rst_valid",    LINE_W'(bus.mcDataOutValid), LINE_W'(0));
    check("rst_data",     bus.mcDataOut, '0);
    check("rst_empty",    LINE_W'(bus.outFifoEmpty),   LINE_W'(1));
    check("rst_overflow", LINE_W'(bus.overflow),       LINE_W'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Back-to-back fill, ready one cycle after the 1024th sample, then full-rate drain.
    fill(NUM_SAMPLES, 32'h0, 1'b0);
    checkFull("full1");
    check("line0_lane0", LINE_W'(bus.mcDataOut[63:0]), LINE_W'(64'h0000_0000_FFFF_FFFF));
    check("line0_lane7", LINE_W'(bus.mcDataOut[511:448]), LINE_W'(64'h0000_0007_FFFF_FFF8));
    check("line0", bus.mcDataOut, expQ[0]);
    drain(1'b0);

    // 50% duty fill with stray handshakes in FILL, randomly spaced drain.
    fill(NUM_SAMPLES, 32'h0, 1'b1);
    checkFull("full2");
    drain(1'b1);

    // Samples during DRAIN are dropped and flag overflow; clr clears it.
    fill(NUM_SAMPLES, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) sendSample(64'hDEAD_BEEF_0000_0000 | 64'(i), 1'b0);
    check("ovf_set", LINE_W'(bus.overflow), LINE_W'(1));
    checkFull("ovf_state");
    drain(1'b1);
    check("ovf_sticky", LINE_W'(bus.overflow), LINE_W'(1));
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("clr_ovf",   LINE_W'(bus.overflow),     LINE_W'(0));
    check("clr_empty", LINE_W'(bus.outFifoEmpty), LINE_W'(1));

    // Async reset mid-fill discards the partial transform.
    fill(500, 32'h1000_0000, 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_empty", LINE_W'(bus.outFifoEmpty), LINE_W'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    idle(1);
    fill(NUM_SAMPLES, 32'h2000_0000, 1'b0);
    checkFull("full_rst");
    drain(1'b0);

    // clr together with a sample: clr wins, the sample is not stored.
    fill(300, 32'h3000_0000, 1'b0);
    clr = 1'b1;
    sendSample(64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
    clr = 1'b0;
    modelReset();
    fill(NUM_SAMPLES, 32'h4000_0000, 1'b0);
    checkFull("full_clr");
    drain(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
